// File: rtl/gray_counter_encoder.sv
// gray_counter_encoder: prescaled up/down binary counter presenting its Gray code through a valid/ready handshake
module gray_counter_encoder #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray_code,
    output logic [WIDTH-1:0] bin_code,
    output logic             gray_valid,
    input  logic             gray_ready,
    output logic             wrap
);
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    logic [PW-1:0]    presc;
    logic             stall, tick, step, wrap_next;
    logic [WIDTH-1:0] count_next;
    // step decision and next count; bin_code doubles as the count register
    always_comb begin
        stall      = gray_valid & ~gray_ready;
        tick       = presc == PW'(DIV - 1);
        step       = en & tick & ~stall & ~load;
        count_next = load ? load_bin : step ? (up_down ? bin_code + WIDTH'(1) : bin_code - WIDTH'(1)) : bin_code;
        wrap_next  = step & (up_down ? &bin_code : ~|bin_code);
    end
    // prescaler advances only on enabled, non-stalled cycles and restarts on tick or load
    always_ff @(posedge clk) begin
        if (rst || load)
            presc <= '0;
        else if (en && !stall)
            presc <= tick ? '0 : presc + PW'(1);
    end
    // count, Gray code, valid and wrap all register together so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_code   <= '0;
            gray_code  <= '0;
            gray_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            bin_code   <= count_next;
            gray_code  <= count_next ^ (count_next >> 1);
            gray_valid <= load | step | stall;
            wrap       <= wrap_next;
        end
    end
endmodule

// File: tb/tb_gray_counter_encoder.sv
// tb_gray_counter_encoder: table, directed and random checks of DIV=1 and DIV=3 encoders against a reference model
module tb_gray_counter_encoder;
    logic       clk = 1'b0;
    logic       rst, en, up_down, load, gray_ready;
    logic [3:0] load_bin;
    logic [3:0] g [2];
    logic [3:0] b [2];
    logic       v [2];
    logic       w [2];
    int checks = 0, failures = 0;
    int m_cnt [2], m_pre [2], m_step [2], m_prev [2];
    bit m_val [2], m_wrap [2];
    int divs [2] = '{1, 3};

    typedef struct {
        logic r, e, u, l;
        logic [3:0] lb;
        logic rd;
        logic [3:0] eg, eb;
        logic ev, ew;
    } vec_t;
    vec_t tbl [15];

    always #5 clk = ~clk;

    gray_counter_encoder #(.WIDTH(4), .DIV(1)) d1 (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_bin(load_bin),
        .gray_code(g[0]), .bin_code(b[0]), .gray_valid(v[0]), .gray_ready(gray_ready), .wrap(w[0])
    );
    gray_counter_encoder #(.WIDTH(4), .DIV(3)) d3 (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load), .load_bin(load_bin),
        .gray_code(g[1]), .bin_code(b[1]), .gray_valid(v[1]), .gray_ready(gray_ready), .wrap(w[1])
    );

    function automatic int gray_of(int x);
        int r = 0;
        for (int i = 0; i < 4; i++)
            if (((x >> i) & 1) != ((x >> (i + 1)) & 1)) r |= 1 << i;
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(int k);
        bit stall, tick, st;
        stall = m_val[k] && !gray_ready;
        m_prev[k] = m_cnt[k];
        m_step[k] = 0;
        if (rst) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_val[k] = 0; m_wrap[k] = 0;
        end else if (load) begin
            m_cnt[k] = int'(load_bin); m_pre[k] = 0; m_val[k] = 1; m_wrap[k] = 0;
        end else begin
            tick = m_pre[k] == divs[k] - 1;
            st = en && tick && !stall;
            m_wrap[k] = st && (up_down ? m_cnt[k] == 15 : m_cnt[k] == 0);
            if (en && !stall) m_pre[k] = tick ? 0 : m_pre[k] + 1;
            if (st) begin
                m_cnt[k] = (m_cnt[k] + (up_down ? 1 : 15)) % 16;
                m_val[k] = 1;
                m_step[k] = 1;
            end else if (gray_ready) m_val[k] = 0;
        end
    endtask

    task automatic cycle();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_gray[%0d]", k), int'(g[k]), gray_of(m_cnt[k]));
            chk($sformatf("model_bin[%0d]", k), int'(b[k]), m_cnt[k]);
            chk($sformatf("model_valid[%0d]", k), int'(v[k]), int'(m_val[k]));
            chk($sformatf("model_wrap[%0d]", k), int'(w[k]), int'(m_wrap[k]));
            if (m_step[k] != 0)
                chk($sformatf("one_bit_change[%0d]", k), $countones(g[k] ^ 4'(gray_of(m_prev[k]))), 1);
        end
    endtask

    initial begin
        tbl[0]  = '{0,1,1,0,4'd0,1,4'b0001,4'd1,1,0};
        tbl[1]  = '{0,1,1,0,4'd0,1,4'b0011,4'd2,1,0};
        tbl[2]  = '{0,1,1,0,4'd0,1,4'b0010,4'd3,1,0};
        tbl[3]  = '{0,1,1,0,4'd0,1,4'b0110,4'd4,1,0};
        tbl[4]  = '{0,0,1,1,4'd14,1,4'b1001,4'd14,1,0};
        tbl[5]  = '{0,1,1,0,4'd0,1,4'b1000,4'd15,1,0};
        tbl[6]  = '{0,1,1,0,4'd0,1,4'b0000,4'd0,1,1};
        tbl[7]  = '{0,1,1,0,4'd0,1,4'b0001,4'd1,1,0};
        tbl[8]  = '{0,0,1,1,4'd1,1,4'b0001,4'd1,1,0};
        tbl[9]  = '{0,1,0,0,4'd0,1,4'b0000,4'd0,1,0};
        tbl[10] = '{0,1,0,0,4'd0,1,4'b1000,4'd15,1,1};
        tbl[11] = '{0,1,0,0,4'd0,1,4'b1001,4'd14,1,0};
        tbl[12] = '{0,1,1,0,4'd0,0,4'b1001,4'd14,1,0};
        tbl[13] = '{0,1,1,0,4'd0,1,4'b1000,4'd15,1,0};
        tbl[14] = '{0,0,1,0,4'd0,1,4'b1000,4'd15,0,0};
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_val[k] = 0; m_wrap[k] = 0; m_step[k] = 0; m_prev[k] = 0;
        end
        rst = 1; en = 1; up_down = 1; load = 1; load_bin = 4'd9; gray_ready = 1;
        cycle();
        cycle();
        chk("reset_gray", int'(g[0]), 0);
        chk("reset_valid", int'(v[0]), 0);
        rst = 0; load = 0;
        // table-driven sequence on the DIV=1 instance
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].r; en = tbl[i].e; up_down = tbl[i].u; load = tbl[i].l;
            load_bin = tbl[i].lb; gray_ready = tbl[i].rd;
            cycle();
            chk($sformatf("tbl%0d_gray", i), int'(g[0]), int'(tbl[i].eg));
            chk($sformatf("tbl%0d_bin", i), int'(b[0]), int'(tbl[i].eb));
            chk($sformatf("tbl%0d_valid", i), int'(v[0]), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_wrap", i), int'(w[0]), int'(tbl[i].ew));
        end
        // backpressure: value 0011 held for 10 stalled cycles, then 0010 follows acceptance
        en = 1; up_down = 1; gray_ready = 0; load = 1; load_bin = 4'd2;
        cycle();
        load = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_gray", int'(g[0]), 4'b0011);
            chk("stall_valid", int'(v[0]), 1);
        end
        gray_ready = 1;
        cycle();
        chk("accept_gray", int'(g[0]), 4'b0010);
        chk("accept_bin", int'(b[0]), 3);
        // prescaler DIV=3 with an enable gap mid-period
        load = 1; load_bin = 4'd0;
        cycle();
        load = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("div3_bin", int'(b[1]), (i + 1) / 3);
        end
        en = 0;
        repeat (5) begin
            cycle();
            chk("div3_hold", int'(b[1]), 1);
        end
        en = 1;
        cycle();
        chk("div3_resume1", int'(b[1]), 1);
        cycle();
        chk("div3_resume2", int'(b[1]), 2);
        // load overrides a stalled pending value
        gray_ready = 0; load = 1; load_bin = 4'd5;
        cycle();
        load_bin = 4'd10;
        cycle();
        chk("ldpri_gray", int'(g[0]), 4'b1111);
        chk("ldpri_bin", int'(b[0]), 10);
        chk("ldpri_valid", int'(v[0]), 1);
        chk("ldpri_wrap", int'(w[0]), 0);
        load = 0; gray_ready = 1;
        cycle();
        cycle();
        chk("ldpri_presc_wait", int'(b[1]), 10);
        cycle();
        chk("ldpri_presc_step", int'(b[1]), 11);
        // reset mid-run beats a simultaneous load
        gray_ready = 0; load = 1; load_bin = 4'd7;
        cycle();
        rst = 1; load_bin = 4'd9;
        cycle();
        chk("rstmid_gray", int'(g[0]), 0);
        chk("rstmid_bin", int'(b[0]), 0);
        chk("rstmid_valid", int'(v[0]), 0);
        chk("rstmid_wrap", int'(w[0]), 0);
        rst = 0; load = 0;
        // randomized stimulus against the model
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom % 60) == 0;
            load = ($urandom % 10) == 0;
            load_bin = 4'($urandom);
            en = ($urandom % 4) != 0;
            if (($urandom % 6) == 0) up_down = ~up_down;
            gray_ready = ($urandom % 3) != 0;
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
